argmax_stream_seq: RTL and testbench
====================================

// Module: argmax_stream_seq
// PURPOSE
//  Readout-stage argmax engine, the parametrised successor of the fixed 3-class arg-max unit.
//  - Accepts one output-feature row per valid/ready handshake (NUM_CLASSES dot-products per node).
//  - Scans the row serially, one compare per cycle, and finds the winning class index and value.
//  - Streams each result out and stores it in a per-node result table, readable by address.
//  - Signals completion after NUM_ROWS nodes; restartable without reset.
// PARAMETERS
//  NUM_ROWS     6                      nodes per graph, i.e. rows per pass
//  NUM_CLASSES  3                      values per row (>=1)
//  DATA_WIDTH   16                     width of each dot-product value
//  SIGNED_CMP   0                      0 = unsigned compare, 1 = two's-complement compare
//  IDX_WIDTH    max(1,$clog2(NUM_CLASSES))  class-index width
//  ROW_WIDTH    max(1,$clog2(NUM_ROWS))     node-index width
// PORTS
//  clk        in   1                      clock, rising edge
//  reset      in   1                      ASYNCHRONOUS, ACTIVE-LOW reset
//  start      in   1                      begin new pass; clears row counter and table
//  in_valid   in   1                      in_row holds a valid row
//  in_ready   out  1                      engine can accept a row
//  in_row     in   DATA_WIDTH x NUM_CLASSES  unpacked [0:NUM_CLASSES-1] row values
//  res_valid  out  1                      one-cycle pulse: result fields valid
//  res_row    out  ROW_WIDTH              node index of result
//  res_idx    out  IDX_WIDTH              winning class index
//  res_max    out  DATA_WIDTH             winning value
//  done       out  1                      one-cycle pulse with the last res_valid of a pass
//  busy       out  1                      high in SCAN/EMIT
//  rd_addr    in   ROW_WIDTH              table read address
//  rd_idx     out  IDX_WIDTH              table[rd_addr], combinational read
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, row counter=0, all table entries=0.
//   in_ready=1; res_valid=0, done=0, busy=0; res_row/res_idx/res_max=0.
//  FSM states: IDLE, SCAN, EMIT, FULL.
//  - IDLE: in_ready=1. On in_valid&&in_ready, latch the whole row, best=row[0], best_idx=0, k=1.
//    Go to SCAN, or to EMIT directly when NUM_CLASSES==1.
//  - SCAN: in_ready=0. Each cycle: if row[k] > best (strict), best=row[k] and best_idx=k; k++.
//    After k==NUM_CLASSES-1 is compared, go to EMIT.
//  - EMIT: res_valid=1 for one cycle; table[row counter]=best_idx.
//    If the row counter is NUM_ROWS-1: done=1, go to FULL, row counter holds.
//    Otherwise increment the row counter and go to IDLE.
//  - FULL: in_ready=0; in_valid ignored; leave only via start or reset.
//  Tie-break: strict greater-than, so the lowest index wins among equal maxima.
//  Compare: SIGNED_CMP=1 uses $signed on both operands; no width extension inside a row.
//  Latency: handshake at cycle t -> res_valid at cycle t+NUM_CLASSES.
//   Throughput: one row per NUM_CLASSES+1 cycles.
//  The row is captured at handshake; in_row may change during SCAN without effect.
//  start (sync, any state): next state IDLE, row counter=0, table cleared, scan aborted, no res_valid.
//   start overrides in_valid in the same cycle: no capture.
//  res_* fields hold their last value between pulses.
//   rd_idx reflects a table write on the cycle after EMIT.
//  Reset mid-SCAN: immediate return to the reset state; the partial row is discarded.
// TESTING
//  1. NUM_CLASSES=3, row {5,9,2} -> res_idx=1, res_max=9, res_row=0, res_valid at t+3.
//  2. Tie {7,7,7} -> res_idx=0; row {3,8,8} -> res_idx=1.
//  3. SIGNED_CMP=1, DATA_WIDTH=16, row {16'hFFFF,16'h0001,16'h8000} -> idx 1.
//     Same row with SIGNED_CMP=0 -> idx 0.
//  4. Six back-to-back rows with in_valid held high -> six res_valid pulses, res_row 0..5.
//     done coincides with res_row=5; in_ready=0 afterwards; rd_addr=0..5 returns the expected indices.
//  5. start asserted during SCAN of row 2 -> no res_valid for that row.
//     Next result has res_row=0; rd_idx=0 for all addresses until rewritten.
//  6. reset driven low mid-SCAN, asynchronously between clock edges -> outputs take reset values immediately.
//     NUM_CLASSES=1 build: res_valid at t+1 with res_idx=0.

Source files
------------

// File: rtl/argmax_stream_seq.sv
// Streaming argmax engine: accepts one row per handshake and scans it serially, one compare per cycle.
// Results are streamed out and also recorded per node in a result table that can be read by address.
module argmax_stream_seq #(
  parameter int NUM_ROWS    = 6,
  parameter int NUM_CLASSES = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int SIGNED_CMP  = 0,
  parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter int ROW_WIDTH   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_row [0:NUM_CLASSES-1],
  output logic                  res_valid,
  output logic [ROW_WIDTH-1:0]  res_row,
  output logic [IDX_WIDTH-1:0]  res_idx,
  output logic [DATA_WIDTH-1:0] res_max,
  output logic                  done,
  output logic                  busy,
  input  logic [ROW_WIDTH-1:0]  rd_addr,
  output logic [IDX_WIDTH-1:0]  rd_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FULL} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] row_q [0:NUM_CLASSES-1];
  logic [DATA_WIDTH-1:0] best;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [IDX_WIDTH-1:0]  k;
  logic [ROW_WIDTH-1:0]  row_cnt;
  logic [IDX_WIDTH-1:0]  res_tab [0:NUM_ROWS-1];

  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_gt;
  logic [DATA_WIDTH-1:0] scan_best;
  logic [IDX_WIDTH-1:0]  scan_idx;
  logic                  last_k;
  logic                  row_last;

  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
    else                 return a > b;
  endfunction

  // Mux-based select keeps the index width independent of the array size.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++)
      if (k == IDX_WIDTH'(i)) cand = row_q[i];
  end

  assign cand_gt   = gt(cand, best);
  assign scan_best = cand_gt ? cand : best;
  assign scan_idx  = cand_gt ? k : best_idx;
  assign last_k    = (k == IDX_WIDTH'(NUM_CLASSES - 1));
  assign row_last  = (row_cnt == ROW_WIDTH'(NUM_ROWS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_nxt = (NUM_CLASSES == 1) ? EMIT : SCAN;
        SCAN: if (last_k)   state_nxt = EMIT;
        EMIT: state_nxt = row_last ? FULL : IDLE;
        FULL: state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SCAN) || (state == EMIT);
  assign res_valid = (state == EMIT) && !start;
  assign done      = res_valid && row_last;

  // Result fields are loaded on entry to EMIT so they are valid with the pulse and hold afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CLASSES; i++) row_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++)    res_tab[i] <= '0;
      best     <= '0;
      best_idx <= '0;
      k        <= '0;
      row_cnt  <= '0;
      res_row  <= '0;
      res_idx  <= '0;
      res_max  <= '0;
    end else if (start) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) res_tab[i] <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          row_q    <= in_row;
          best     <= in_row[0];
          best_idx <= '0;
          k        <= IDX_WIDTH'(1);
          if (NUM_CLASSES == 1) begin
            res_max <= in_row[0];
            res_idx <= '0;
            res_row <= row_cnt;
          end
        end
        SCAN: begin
          best     <= scan_best;
          best_idx <= scan_idx;
          k        <= k + IDX_WIDTH'(1);
          if (last_k) begin
            res_max <= scan_best;
            res_idx <= scan_idx;
            res_row <= row_cnt;
          end
        end
        EMIT: begin
          res_tab[row_cnt] <= best_idx;
          if (!row_last) row_cnt <= row_cnt + ROW_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_idx = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++)
      if (rd_addr == ROW_WIDTH'(i)) rd_idx = res_tab[i];
  end

endmodule

// File: tb/tb_argmax_stream_seq.sv
// Directed bench for argmax_stream_seq: unsigned 3-class, signed 3-class and 1-class builds.
module tb_argmax_stream_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] row3 [0:2];
  logic [15:0] row1 [0:0];

  logic mv = 1'b0, sv = 1'b0, ov = 1'b0;
  logic m_rdy, m_rv, m_done, m_busy; logic [2:0] m_row; logic [1:0] m_idx, m_rd; logic [15:0] m_max;
  logic s_rdy, s_rv, s_done, s_busy; logic [2:0] s_row; logic [1:0] s_idx, s_rd; logic [15:0] s_max;
  logic o_rdy, o_rv, o_done, o_busy; logic [2:0] o_row; logic [0:0] o_idx, o_rd; logic [15:0] o_max;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  argmax_stream_seq u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(mv), .in_ready(m_rdy), .in_row(row3),
    .res_valid(m_rv), .res_row(m_row), .res_idx(m_idx), .res_max(m_max), .done(m_done),
    .busy(m_busy), .rd_addr(rd_addr), .rd_idx(m_rd));

  argmax_stream_seq #(.SIGNED_CMP(1)) u_sgn (
    .clk(clk), .reset(reset), .start(start), .in_valid(sv), .in_ready(s_rdy), .in_row(row3),
    .res_valid(s_rv), .res_row(s_row), .res_idx(s_idx), .res_max(s_max), .done(s_done),
    .busy(s_busy), .rd_addr(rd_addr), .rd_idx(s_rd));

  argmax_stream_seq #(.NUM_CLASSES(1)) u_one (
    .clk(clk), .reset(reset), .start(start), .in_valid(ov), .in_ready(o_rdy), .in_row(row1),
    .res_valid(o_rv), .res_row(o_row), .res_idx(o_idx), .res_max(o_max), .done(o_done),
    .busy(o_busy), .rd_addr(rd_addr), .rd_idx(o_rd));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    row3[0] = a; row3[1] = b; row3[2] = c;
  endtask

  task automatic run_row(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input int ei, input int em, input int er);
    set_row(a, b, c);
    mv = 1'b1;
    chk("rdy_before", m_rdy, 1);
    step;
    mv = 1'b0;
    chk("busy_scan", m_busy, 1);
    chk("rv_t1", m_rv, 0);
    step;
    chk("rv_t2", m_rv, 0);
    step;
    chk("rv_t3", m_rv, 1);
    chk("res_idx", m_idx, ei);
    chk("res_max", m_max, em);
    chk("res_row", m_row, er);
    chk("done_mid", m_done, 0);
    step;
    chk("rv_after", m_rv, 0);
    chk("idx_hold", m_idx, ei);
  endtask

  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input int mi, input int mm, input int mr,
                          input int si, input int sm, input int sr);
    set_row(a, b, c);
    mv = 1'b1; sv = 1'b1;
    step;
    mv = 1'b0; sv = 1'b0;
    step;
    step;
    chk("u_rv", m_rv, 1);
    chk("u_idx", m_idx, mi);
    chk("u_max", m_max, mm);
    chk("u_row", m_row, mr);
    chk("s_rv", s_rv, 1);
    chk("s_idx", s_idx, si);
    chk("s_max", s_max, sm);
    chk("s_row", s_row, sr);
    step;
  endtask

  logic [15:0] pa [6] = '{16'd3, 16'd10, 16'd4, 16'd0, 16'd1, 16'd100};
  logic [15:0] pb [6] = '{16'd8, 16'd2,  16'd4, 16'd0, 16'd2, 16'd200};
  logic [15:0] pc [6] = '{16'd8, 16'd30, 16'd1, 16'd0, 16'd3, 16'd150};
  int          ei [6] = '{1, 2, 0, 0, 2, 1};
  int          em [6] = '{8, 30, 4, 0, 3, 200};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int send, recv, acc;
    set_row(16'd0, 16'd0, 16'd0);
    row1[0] = 16'd0;

    // reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_rdy", m_rdy, 1);
    chk("rst_rv", m_rv, 0);
    chk("rst_done", m_done, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_row", m_row, 0);
    chk("rst_idx", m_idx, 0);
    chk("rst_max", m_max, 0);
    chk("rst_rd", m_rd, 0);
    step;
    #3 reset = 1'b1;
    step;

    // basic rows and tie-break
    run_row(16'd5, 16'd9, 16'd2, 1, 9, 0);
    rd_addr = 3'd0; #1;
    chk("rd0_first", m_rd, 1);
    run_row(16'd7, 16'd7, 16'd7, 0, 7, 1);

    // start during SCAN aborts the row
    set_row(16'd9, 16'd1, 16'd1);
    mv = 1'b1;
    step;
    mv = 1'b0;
    start = 1'b1;
    chk("abort_busy", m_busy, 1);
    chk("abort_rv", m_rv, 0);
    step;
    start = 1'b0;
    chk("abort_idle", m_busy, 0);
    chk("abort_rdy", m_rdy, 1);
    chk("abort_max_hold", m_max, 7);
    chk("abort_row_hold", m_row, 1);
    for (int a = 0; a < 6; a++) begin
      rd_addr = 3'(a); #1;
      chk("abort_rd_clear", m_rd, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step;
      chk("abort_no_rv", m_rv, 0);
    end

    // start overrides in_valid in the same cycle
    start = 1'b1; mv = 1'b1;
    step;
    start = 1'b0; mv = 1'b0;
    chk("ovr_busy", m_busy, 0);
    chk("ovr_rdy", m_rdy, 1);
    step;
    chk("ovr_no_rv", m_rv, 0);

    // six back-to-back rows with in_valid held high
    send = 0; recv = 0; acc = -100;
    mv = 1'b1;
    set_row(pa[0], pb[0], pc[0]);
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      chk("b2b_rv", m_rv, (cyc == acc + 3));
      if (m_rv) begin
        chk("b2b_row", m_row, recv);
        chk("b2b_idx", m_idx, ei[recv]);
        chk("b2b_max", m_max, em[recv]);
        chk("b2b_done", m_done, (recv == 5));
        recv++;
      end
      if (m_rdy && send < 6) begin
        if (send > 0) chk("b2b_gap", cyc - acc, 4);
        acc = cyc;
        send++;
      end
      step;
      if (send < 6) set_row(pa[send], pb[send], pc[send]);
      else          set_row(16'hFFFF, 16'hFFFF, 16'hFFFF);
    end
    chk("b2b_count", recv, 6);
    chk("full_rdy", m_rdy, 0);
    chk("full_busy", m_busy, 0);
    chk("full_rv", m_rv, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("full_ignore", m_rv, 0);
    end
    mv = 1'b0;
    for (int a = 0; a < 6; a++) begin
      rd_addr = 3'(a); #1;
      chk("full_rd", m_rd, ei[a]);
    end

    // restart from FULL
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("restart_rdy", m_rdy, 1);
    rd_addr = 3'd5; #1;
    chk("restart_rd5", m_rd, 0);
    run_row(16'd5, 16'd9, 16'd2, 1, 9, 0);

    // signed versus unsigned compare
    run_pair(16'hFFFF, 16'h0001, 16'h8000, 0, 16'hFFFF, 1, 1, 16'h0001, 0);
    run_pair(16'h7FFF, 16'h8000, 16'h7FFF, 1, 16'h8000, 2, 0, 16'h7FFF, 1);

    // single-class build: result one cycle after the handshake
    chk("one_rv_idle", o_rv, 0);
    row1[0] = 16'h0042;
    ov = 1'b1;
    chk("one_rdy", o_rdy, 1);
    step;
    ov = 1'b0;
    chk("one_rv", o_rv, 1);
    chk("one_idx", o_idx, 0);
    chk("one_max", o_max, 16'h0042);
    chk("one_row", o_row, 0);
    step;
    chk("one_rv_off", o_rv, 0);
    chk("one_rdy_back", o_rdy, 1);
    row1[0] = 16'd7;
    ov = 1'b1;
    step;
    ov = 1'b0;
    chk("one_rv2", o_rv, 1);
    chk("one_row2", o_row, 1);
    chk("one_max2", o_max, 7);
    step;

    // asynchronous reset in the middle of a scan
    rd_addr = 3'd0;
    set_row(16'd1, 16'd2, 16'd3);
    mv = 1'b1;
    step;
    mv = 1'b0;
    step;
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", m_busy, 0);
    chk("arst_rdy", m_rdy, 1);
    chk("arst_rv", m_rv, 0);
    chk("arst_row", m_row, 0);
    chk("arst_idx", m_idx, 0);
    chk("arst_max", m_max, 0);
    chk("arst_rd0", m_rd, 0);
    chk("arst_one_max", o_max, 0);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("arst_no_rv", m_rv, 0);
    end
    chk("arst_idle", m_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
